// File: rtl/hwag_crank_emu.sv
// Crank trigger-wheel emulator: missing-tooth wheel with tooth index and rev strobe.
// Optional cam phase output enabled by defining HWAG_CRANK_EMU_CAM_EN.
module hwag_crank_emu #(
  parameter int PERIOD_WIDTH  = 24,
  parameter int TOOTH_TOTAL   = 60,
  parameter int TOOTH_MISSING = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [PERIOD_WIDTH-1:0] period_in,
  input  logic                    period_wr,
  output logic                    crank_out,
  output logic [7:0]              tooth_num,
  output logic                    gap_active,
  output logic                    rev_pulse,
  output logic                    busy,
  output logic                    cam_out
);

  localparam int CW = PERIOD_WIDTH + 1;
  localparam logic [7:0] LAST = 8'(TOOTH_TOTAL - TOOTH_MISSING - 1);
  localparam logic [PERIOD_WIDTH-1:0] P_MIN = PERIOD_WIDTH'(4);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] p_shadow;
  logic [PERIOD_WIDTH-1:0] p_act;
  logic [CW-1:0]           cnt;

  logic          done;
  logic [CW-1:0] hi_len;
  logic [CW-1:0] lo_len;
  logic [CW-1:0] gap_len;
  logic          start_rev;
  logic          next_tooth;
  logic          to_idle;

  assign done    = (cnt == CW'(1));
  assign hi_len  = {1'b0, p_shadow >> 1};
  assign lo_len  = {1'b0, p_act - (p_act >> 1)};
  assign gap_len = CW'(TOOTH_MISSING) * {1'b0, p_act};

  assign start_rev  = (state == IDLE && ena) ||
                      (state == GAP && done && ena);
  assign next_tooth = state == LOW && done && ena &&
                      tooth_num != LAST;
  assign to_idle    = (state == LOW || state == GAP) &&
                      done && !ena;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_shadow <= P_MIN;
    end else if (period_wr) begin
      p_shadow <= (period_in < P_MIN) ? P_MIN : period_in;
    end
  end

  // HIGH entry copies the shadow, so a tooth in progress keeps its period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      p_act      <= P_MIN;
      cnt        <= '0;
      crank_out  <= 1'b0;
      tooth_num  <= 8'd0;
      gap_active <= 1'b0;
      rev_pulse  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rev_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ena) begin
            state     <= HIGH;
            p_act     <= p_shadow;
            cnt       <= hi_len;
            crank_out <= 1'b1;
            tooth_num <= 8'd0;
            rev_pulse <= 1'b1;
            busy      <= 1'b1;
          end
        end
        HIGH: begin
          if (done) begin
            state     <= LOW;
            cnt       <= lo_len;
            crank_out <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        LOW: begin
          if (!done) begin
            cnt <= cnt - CW'(1);
          end else if (!ena) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tooth_num == LAST) begin
            state      <= GAP;
            cnt        <= gap_len;
            gap_active <= 1'b1;
          end else begin
            state     <= HIGH;
            p_act     <= p_shadow;
            cnt       <= hi_len;
            crank_out <= 1'b1;
            tooth_num <= tooth_num + 8'd1;
          end
        end
        GAP: begin
          if (!done) begin
            cnt <= cnt - CW'(1);
          end else begin
            gap_active <= 1'b0;
            if (!ena) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state     <= HIGH;
              p_act     <= p_shadow;
              cnt       <= hi_len;
              crank_out <= 1'b1;
              tooth_num <= 8'd0;
              rev_pulse <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HWAG_CRANK_EMU_CAM_EN
  logic parity;

  function automatic logic in_cam(input logic [7:0] t);
    return t >= 8'd2 && t <= 8'd5;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity  <= 1'b0;
      cam_out <= 1'b0;
    end else if (to_idle) begin
      parity  <= 1'b0;
      cam_out <= 1'b0;
    end else if (start_rev) begin
      parity  <= ~parity;
      cam_out <= 1'b0;
    end else if (next_tooth) begin
      cam_out <= parity & in_cam(tooth_num + 8'd1);
    end
  end
`else
  logic unused_ev;
  assign unused_ev = start_rev ^ next_tooth ^ to_idle;
  assign cam_out   = 1'b0;
`endif

endmodule

// File: doc/hwag_crank_emu.md
# hwag_crank_emu

Crank trigger-wheel emulator: the transmit end of the HWAG crank input. It generates a missing-tooth wheel signal (60-2 by default) from a programmable tooth period in clock cycles, plus tooth index, gap flag and a once-per-revolution strobe. It drives the HWAG `cap_in` path for closed-loop bench tests and on-board self-test, replacing a physical VR sensor.

## Interface
- `PERIOD_WIDTH`, 24: tooth period register width, in clock cycles.
- `TOOTH_TOTAL`, 60: tooth positions per revolution, including missing ones.
- `TOOTH_MISSING`, 2: number of missing positions forming the gap.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  run request; level-sensitive.
- `period_in`  in  PERIOD_WIDTH  requested tooth period P, in clock cycles.
- `period_wr`  in  1  one-cycle strobe; latches `period_in` into the shadow register.
- `crank_out`  out  1  emulated wheel signal; falling edge is the tooth event.
- `tooth_num`  out  8  index of the current physical tooth, 0..TOOTH_TOTAL-TOOTH_MISSING-1.
- `gap_active`  out  1  high while the missing-tooth gap is being emitted.
- `rev_pulse`  out  1  one-cycle strobe at the start of tooth 0.
- `busy`  out  1  high whenever the state is not IDLE.
- `cam_out`  out  1  cam phase signal; see Configuration.

## Operation
- Period handling:
  - Shadow register `p_shadow` resets to 4.
  - `period_wr` loads `period_in`, clamped to a minimum of 4.
  - Active period `p_act` is copied from `p_shadow` on every entry to HIGH, so a tooth in progress is never altered.
- Tooth halves: `P_hi = p_act >> 1`, `P_lo = p_act - P_hi`. An odd P puts the extra cycle in the low phase.
- Phase counter: down-counter, PERIOD_WIDTH+1 bits wide so it can hold 2·P for the gap. It is loaded on each state entry and the state advances when it reaches 1.
- States:
  - IDLE: `crank_out`=0. If `ena`=1, go to HIGH with `tooth_num`=0 and `rev_pulse`=1.
  - HIGH: `crank_out`=1 for `P_hi` cycles, then go to LOW.
  - LOW: `crank_out`=0 for `P_lo` cycles, then:
    - if `ena`=0, go to IDLE;
    - else if `tooth_num` = TOOTH_TOTAL-TOOTH_MISSING-1, go to GAP;
    - else go to HIGH with `tooth_num`+1.
  - GAP: `crank_out`=0 and `gap_active`=1 for TOOTH_MISSING·`p_act` cycles, then:
    - if `ena`=0, go to IDLE;
    - else go to HIGH with `tooth_num`=0 and `rev_pulse`=1.
- Resulting spacing between falling edges: P between physical teeth; (TOOTH_MISSING+1)·P from the last tooth to tooth 0.
- Stopping: deasserting `ena` never truncates a tooth or a gap; the block stops only at the LOW or GAP exit. Re-enabling always restarts at tooth 0.
- Reset mid-operation: all state clears immediately. The output is low with no glitch pulse.
- Reset values: `crank_out`=0, `tooth_num`=0, `gap_active`=0, `rev_pulse`=0, `busy`=0, `cam_out`=0, state IDLE.

## Timing
- All outputs are registered; none has a combinational path from any input.
- Start latency: the clock edge that samples `ena`=1 in IDLE also sets `crank_out`=1 and `rev_pulse`=1. Both are visible in the following cycle.
- `period_wr` latency: the written value is used from the next HIGH entry. When `period_wr` coincides with a HIGH entry, the old shadow value is used for that tooth.
- `tooth_num` changes on the same edge as the rising `crank_out`.
- `gap_active` rises on the edge on which `crank_out` would otherwise have risen for the first missing tooth.

## Configuration
- `HWAG_CRANK_EMU_CAM_EN`, defined:
  - A revolution-parity flip-flop toggles on each `rev_pulse`; it resets to 0 and is set to 1 by the first `rev_pulse`.
  - `cam_out`=1 while parity=1 and `tooth_num` is 2..5 inclusive, giving one cam pulse per two revolutions.
  - Both the parity flop and `cam_out` clear on `rst`, and when returning to IDLE.
- Not defined: `cam_out` is tied to 0, the parity logic is absent, and the port list is unchanged.

## Test plan
- Free-run: P=100, `ena`=1 -> high 50 / low 50 per tooth; 58 falling edges spaced 100 clk; tooth 57 fall to tooth 0 fall = 300 clk; `rev_pulse` every 6000 clk.
- Odd and clamped periods: P=101 -> high 50 / low 51; P=2 -> clamped to 4, high 2 / low 2.
- Period change: `period_wr` with 200 during the HIGH of tooth 10 (P=100) -> tooth 10 stays 100 clk; tooth 11 onwards is 200 clk.
- Stop: `ena`→0 during the HIGH of tooth 5 -> tooth 5 completes in full; IDLE at the end of its LOW; `busy`=0. Re-enable -> `rev_pulse` and `tooth_num`=0.
- Reset mid-gap: `rst`=0 during GAP -> all outputs 0 asynchronously, state IDLE, `p_shadow`=4.
- Cam (with `HWAG_CRANK_EMU_CAM_EN`), P=100 -> `cam_out` high for 400 clk during teeth 2..5 of the 1st, 3rd, 5th… revolutions; low throughout the 2nd, 4th….
